// File: rtl/debug_pkg.sv
// Shared constants for the pipeline debug controller.
// Holds the UART-style command codes, the default halt instruction, the
// controller state encoding and the dump layout (word counts and sizes).
// No ports; imported by pipeline_debug_controller and word_serializer.
package debug_pkg;

    // Command bytes recognised while the controller is idle
    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_RUN  = 8'h43;  // 'C'

    // Instruction word that ends a continuous run when it is fetched
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Dump layout: PC and ALU result, then the register file, then data memory
    localparam int DUMP_FIXED_WORDS = 2;
    localparam int DUMP_REG_WORDS   = 32;
    localparam int BYTES_PER_WORD   = 4;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LOAD_COUNT = 4'd1,
        ST_LOAD_BYTE  = 4'd2,
        ST_LOAD_WRITE = 4'd3,
        ST_STEP       = 4'd4,
        ST_RUN        = 4'd5,
        ST_DUMP_SEL   = 4'd6,
        ST_DUMP_WAIT  = 4'd7,
        ST_DUMP_SEND  = 4'd8
    } dbg_state_e;

    // Total number of words sent by one dump
    function automatic int dump_words(input int mem_words);
        return DUMP_FIXED_WORDS + DUMP_REG_WORDS + mem_words;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Word serializer: takes one NB-bit word and emits it as NB/8 bytes, MSB
// first, with a valid/ready handshake. Each byte is held stable until the
// sink accepts it.
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_load, i_word   capture a new word (ignored while a word is in flight)
//   i_tx_ready       sink accepts the current byte this cycle
//   o_tx_data        current byte
//   o_tx_valid       current byte is valid
//   o_done           pulses in the cycle the final byte is accepted
module word_serializer
    import debug_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [NB-1:0] i_word,
    input  logic          i_tx_ready,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    output logic          o_done
);

    localparam int NBYTES = NB / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [NB-1:0] word_q, word_d;
    logic [IW-1:0] byte_idx_q, byte_idx_d;
    logic          valid_q, valid_d;
    logic [NB-1:0] shifted;

    // Register stage; reset drops any byte in flight so nothing more is sent
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            word_q     <= '0;
            byte_idx_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            valid_q    <= valid_d;
        end
    end

    // A new word is only accepted when idle; otherwise advance on each
    // accepted byte and signal completion on the last one
    always_comb begin
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        valid_d    = valid_q;
        o_done     = 1'b0;
        if (!valid_q) begin
            if (i_load) begin
                word_d     = i_word;
                byte_idx_d = '0;
                valid_d    = 1'b1;
            end
        end else if (i_tx_ready) begin
            if (byte_idx_q == IW'(NBYTES - 1)) begin
                valid_d = 1'b0;
                o_done  = 1'b1;
            end else begin
                byte_idx_d = byte_idx_q + 1'b1;
            end
        end
    end

    // Shift the selected byte up to the top so byte 0 is the MSB
    assign shifted    = word_q << {byte_idx_q, 3'b000};
    assign o_tx_data  = shifted[NB-1 -: 8];
    assign o_tx_valid = valid_q;

endmodule

// File: rtl/pipeline_debug_controller.sv
// Pipeline debug controller: a byte-command front end for a MIPS-style
// pipeline. 'L' loads N instruction words into instruction memory, 'S'
// advances the pipeline one cycle, 'C' runs until the halt word is fetched
// or MAX_RUN cycles elapse. Step and run end with a full state dump
// (PC, ALU result, R0..R31, M0..M(MEM_WORDS-1)) sent as bytes.
// Ports:
//   i_clk, i_reset                 clock and synchronous active-high reset
//   i_rx_data, i_rx_valid          incoming command/payload byte strobe
//   o_tx_data, o_tx_valid, i_tx_ready  dump byte stream with handshake
//   o_step                         pipeline advance enable
//   o_instruction_*                instruction-memory write port
//   o_debug_register_number        register-file debug read select
//   o_debug_address                data-memory debug read word address
//   i_mips_*                       observed pipeline values
//   o_busy, o_halted               status
module pipeline_debug_controller
    import debug_pkg::*;
#(
    parameter int               NB        = 32,
    parameter int               NB_REGS   = 5,
    parameter int               MEM_WORDS = 16,
    parameter int               MAX_RUN   = 1024,
    parameter logic [NB-1:0]    HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_step,
    output logic               o_instruction_write_enable,
    output logic [NB-1:0]      o_instruction_address,
    output logic [NB-1:0]      o_instruction_data,
    output logic [NB_REGS-1:0] o_debug_register_number,
    output logic [NB-1:0]      o_debug_address,
    input  logic [NB-1:0]      i_mips_pc,
    input  logic [NB-1:0]      i_mips_alu_result,
    input  logic [NB-1:0]      i_mips_register_data,
    input  logic [NB-1:0]      i_mips_data_memory,
    output logic               o_busy,
    output logic               o_halted
);

    localparam int DUMP_WORDS = dump_words(MEM_WORDS);
    localparam int DW         = $clog2(DUMP_WORDS);
    localparam int RW         = $clog2(MAX_RUN + 1);
    localparam int MEM_BASE   = DUMP_FIXED_WORDS + DUMP_REG_WORDS;

    dbg_state_e    state_q, state_d;
    logic [7:0]    word_count_q, word_count_d;
    logic [7:0]    word_idx_q, word_idx_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [NB-1:0] assembly_q, assembly_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic [DW-1:0] dump_idx_q, dump_idx_d;
    logic          halted_q, halted_d;
    logic          loaded_q, loaded_d;

    logic          ser_load;
    logic          ser_done;
    logic          is_reg_word;
    logic          is_mem_word;
    logic          run_stop;
    logic [NB-1:0] dump_word;

    // State register and all counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            assembly_q   <= '0;
            run_cnt_q    <= '0;
            dump_idx_q   <= '0;
            halted_q     <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            assembly_q   <= assembly_d;
            run_cnt_q    <= run_cnt_d;
            dump_idx_q   <= dump_idx_d;
            halted_q     <= halted_d;
            loaded_q     <= loaded_d;
        end
    end

    // Dump index decoding: the debug selects stay at zero whenever the index
    // is on the PC/ALU words, which is also the idle value
    assign is_reg_word = (dump_idx_q >= DW'(DUMP_FIXED_WORDS)) && (dump_idx_q < DW'(MEM_BASE));
    assign is_mem_word = (dump_idx_q >= DW'(MEM_BASE));

    assign o_debug_register_number = is_reg_word ? NB_REGS'(dump_idx_q - DW'(DUMP_FIXED_WORDS)) : '0;
    assign o_debug_address         = is_mem_word ? NB'(dump_idx_q - DW'(MEM_BASE)) : '0;

    // Word handed to the serializer; the select has been stable since DUMP_SEL
    always_comb begin
        dump_word = i_mips_data_memory;
        if (dump_idx_q == DW'(0)) begin
            dump_word = i_mips_pc;
        end else if (dump_idx_q == DW'(1)) begin
            dump_word = i_mips_alu_result;
        end else if (is_reg_word) begin
            dump_word = i_mips_register_data;
        end
    end

    // A fetched halt word and hitting the cycle limit in the same cycle lead
    // to the same single stop
    assign run_stop = (i_mips_pc == HALT_WORD) || (run_cnt_q == RW'(MAX_RUN));

    // Next-state logic. o_step is only ever raised in STEP and RUN, so the
    // pipeline stays frozen while loading and while being dumped
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        assembly_d   = assembly_q;
        run_cnt_d    = run_cnt_q;
        dump_idx_d   = dump_idx_q;
        halted_d     = halted_q;
        loaded_d     = loaded_q;
        o_step       = 1'b0;
        ser_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        halted_d = 1'b0;
                        state_d  = ST_LOAD_COUNT;
                    end else if (!halted_q && i_rx_data == CMD_STEP) begin
                        state_d = ST_STEP;
                    end else if (!halted_q && i_rx_data == CMD_RUN) begin
                        run_cnt_d = '0;
                        state_d   = ST_RUN;
                    end
                end
            end

            ST_LOAD_COUNT: begin
                if (i_rx_valid) begin
                    word_count_d = i_rx_data;
                    word_idx_d   = '0;
                    byte_cnt_d   = '0;
                    state_d      = (i_rx_data == 8'd0) ? ST_IDLE : ST_LOAD_BYTE;
                end
            end

            ST_LOAD_BYTE: begin
                if (i_rx_valid) begin
                    assembly_d = {assembly_q[NB-9:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_LOAD_WRITE;
                    end
                end
            end

            ST_LOAD_WRITE: begin
                word_idx_d = word_idx_q + 8'd1;
                state_d    = ((word_idx_q + 8'd1) == word_count_q) ? ST_IDLE : ST_LOAD_BYTE;
            end

            ST_STEP: begin
                o_step     = 1'b1;
                dump_idx_d = '0;
                state_d    = ST_DUMP_SEL;
            end

            ST_RUN: begin
                if (run_stop) begin
                    halted_d   = 1'b1;
                    dump_idx_d = '0;
                    state_d    = ST_DUMP_SEL;
                end else begin
                    o_step    = 1'b1;
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end

            ST_DUMP_SEL: begin
                loaded_d = 1'b0;
                state_d  = ST_DUMP_WAIT;
            end

            ST_DUMP_WAIT: begin
                state_d = ST_DUMP_SEND;
            end

            // First cycle captures the word; then wait for its last byte
            ST_DUMP_SEND: begin
                if (!loaded_q) begin
                    ser_load = 1'b1;
                    loaded_d = 1'b1;
                end else if (ser_done) begin
                    loaded_d = 1'b0;
                    if (dump_idx_q == DW'(DUMP_WORDS - 1)) begin
                        dump_idx_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        dump_idx_d = dump_idx_q + 1'b1;
                        state_d    = ST_DUMP_SEL;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_instruction_write_enable = (state_q == ST_LOAD_WRITE);
    assign o_instruction_address      = (state_q == ST_LOAD_WRITE) ? NB'({word_idx_q, 2'b00}) : '0;
    assign o_instruction_data         = (state_q == ST_LOAD_WRITE) ? assembly_q : '0;
    assign o_busy                     = (state_q != ST_IDLE);
    assign o_halted                   = halted_q;

    word_serializer #(
        .NB(NB)
    ) u_serializer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (ser_load),
        .i_word     (dump_word),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_done     (ser_done)
    );

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Testbench for pipeline_debug_controller. A small behavioural pipeline
// (program array, register file, data memory, step counter) stands in for
// the MIPS core; expected write pulses and dump bytes are computed from the
// command rules and compared against what the controller produces.
module tb_pipeline_debug_controller;

    localparam int          NB         = 32;
    localparam int          NB_REGS    = 5;
    localparam int          MEM_WORDS  = 16;
    localparam int          MAX_RUN    = 20;
    localparam logic [31:0] HALT       = 32'hFFFF_FFFF;
    localparam int          DUMP_BYTES = (2 + 32 + MEM_WORDS) * 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               step;
    logic               instr_we;
    logic [NB-1:0]      instr_addr;
    logic [NB-1:0]      instr_data;
    logic [NB_REGS-1:0] dbg_reg;
    logic [NB-1:0]      dbg_addr;
    logic [NB-1:0]      mips_pc;
    logic [NB-1:0]      mips_alu;
    logic [NB-1:0]      reg_data;
    logic [NB-1:0]      mem_data;
    logic               busy;
    logic               halted;

    always #5 clk = ~clk;

    pipeline_debug_controller #(
        .NB        (NB),
        .NB_REGS   (NB_REGS),
        .MEM_WORDS (MEM_WORDS),
        .MAX_RUN   (MAX_RUN),
        .HALT_WORD (HALT)
    ) dut (
        .i_clk                      (clk),
        .i_reset                    (reset),
        .i_rx_data                  (rx_data),
        .i_rx_valid                 (rx_valid),
        .o_tx_data                  (tx_data),
        .o_tx_valid                 (tx_valid),
        .i_tx_ready                 (tx_ready),
        .o_step                     (step),
        .o_instruction_write_enable (instr_we),
        .o_instruction_address      (instr_addr),
        .o_instruction_data         (instr_data),
        .o_debug_register_number    (dbg_reg),
        .o_debug_address            (dbg_addr),
        .i_mips_pc                  (mips_pc),
        .i_mips_alu_result          (mips_alu),
        .i_mips_register_data       (reg_data),
        .i_mips_data_memory         (mem_data),
        .o_busy                     (busy),
        .o_halted                   (halted)
    );

    // Pipeline model state
    logic [31:0] prog_mem [64];
    logic [31:0] reg_file [32];
    logic [31:0] data_mem [MEM_WORDS];
    logic [31:0] load_words [64];
    int          step_count = 0;

    // Observed traffic
    logic [7:0]  tx_q [$];
    logic [63:0] wr_q [$];
    int          step_pulses    = 0;
    int          stall_checks   = 0;
    int          stall_errors   = 0;
    int          overlap_errors = 0;
    logic        prev_hold      = 1'b0;
    logic [7:0]  prev_data      = 8'h00;

    int          total  = 0;
    int          passed = 0;

    logic        ready_force = 1'b0;
    logic        ready_val   = 1'b1;

    function automatic logic [31:0] alu_fn(input int s);
        return (32'(s) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h1234_5678;
        return w;
    endfunction

    // The fetched word is the program entry at the number of steps taken
    assign mips_pc  = prog_mem[step_count];
    assign mips_alu = alu_fn(step_count);

    // Pipeline advances on o_step; debug reads have one cycle of latency
    always @(posedge clk) begin
        if (reset) step_count <= 0;
        else if (step) step_count <= step_count + 1;
        reg_data <= reg_file[dbg_reg];
        mem_data <= data_mem[dbg_addr[3:0]];
    end

    // Observe outputs mid-cycle; inputs are only changed just after rising edges
    always @(negedge clk) begin
        if (instr_we) wr_q.push_back({instr_addr, instr_data});
        if (step) step_pulses <= step_pulses + 1;
        if (step && (tx_valid || instr_we)) overlap_errors <= overlap_errors + 1;
        if (prev_hold) begin
            stall_checks <= stall_checks + 1;
            if (!(tx_valid === 1'b1 && tx_data === prev_data)) stall_errors <= stall_errors + 1;
        end
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        prev_hold <= tx_valid && !tx_ready;
        prev_data <= tx_data;
    end

    // Sink readiness: random unless the main sequence forces a level
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wr_q.delete();
        tx_q.delete();
    endtask

    // Sends 'L', N and the words in load_words, then checks the write pulses
    task automatic load_program(input int n, input string tag);
        logic [31:0] w;
        wr_q.delete();
        applyStimulus(8'h4C);
        applyStimulus(8'(n));
        for (int i = 0; i < n; i++) begin
            w = load_words[i];
            applyStimulus(w[31:24]);
            applyStimulus(w[23:16]);
            applyStimulus(w[15:8]);
            applyStimulus(w[7:0]);
            prog_mem[i] = w;
        end
        wait_idle(tag, 50);
        checkOutput({tag, "_writes"}, 64'(wr_q.size()), 64'(n));
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), {32'd0, wr_q[i][63:32]}, 64'(4 * i));
            checkOutput($sformatf("%s_data%0d", tag, i), {32'd0, wr_q[i][31:0]}, {32'd0, load_words[i]});
        end
    endtask

    // Expected dump for a pipeline that has taken exp_steps steps
    task automatic check_dump(input int exp_steps, input string tag);
        logic [31:0] words [$];
        logic [31:0] w;
        logic [7:0]  e;
        words.push_back(prog_mem[exp_steps]);
        words.push_back(alu_fn(exp_steps));
        for (int r = 0; r < 32; r++) words.push_back(reg_file[r]);
        for (int m = 0; m < MEM_WORDS; m++) words.push_back(data_mem[m]);
        checkOutput({tag, "_count"}, 64'(tx_q.size()), 64'(DUMP_BYTES));
        for (int i = 0; i < DUMP_BYTES && i < tx_q.size(); i++) begin
            w = words[i / 4];
            e = 8'(w >> (8 * (3 - (i % 4))));
            checkOutput($sformatf("%s_byte%0d", tag, i), {56'd0, tx_q[i]}, {56'd0, e});
        end
        tx_q.delete();
    endtask

    initial begin
        int base;
        int sbase;
        int ebase;
        int n;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 64; i++) prog_mem[i] = rnd_word();
        for (int i = 0; i < 32; i++) reg_file[i] = $urandom;
        for (int i = 0; i < MEM_WORDS; i++) data_mem[i] = $urandom;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_halted", {63'd0, halted}, 64'd0);
        checkOutput("rst_step", {63'd0, step}, 64'd0);
        checkOutput("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        checkOutput("rst_we", {63'd0, instr_we}, 64'd0);
        checkOutput("rst_iaddr", {32'd0, instr_addr}, 64'd0);
        checkOutput("rst_idata", {32'd0, instr_data}, 64'd0);
        checkOutput("rst_dbg_reg", {59'd0, dbg_reg}, 64'd0);
        checkOutput("rst_dbg_addr", {32'd0, dbg_addr}, 64'd0);
        reset = 1'b0;
        wr_q.delete();
        tx_q.delete();

        // Unknown bytes in idle are ignored
        base = step_pulses;
        applyStimulus(8'h00);
        applyStimulus(8'h58);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("junk_busy", {63'd0, busy}, 64'd0);
        checkOutput("junk_writes", 64'(wr_q.size()), 64'd0);
        checkOutput("junk_steps", 64'(step_pulses - base), 64'd0);

        // Two-word load
        $display("[TB] load two words");
        load_words[0] = 32'h2001_0005;
        load_words[1] = HALT;
        load_program(2, "load2");

        // Reset after two payload bytes aborts the load
        $display("[TB] reset mid-load");
        applyStimulus(8'h4C);
        applyStimulus(8'h01);
        applyStimulus(8'hDE);
        applyStimulus(8'hAD);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_writes", 64'(wr_q.size()), 64'd0);
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        load_words[0] = rnd_word();
        load_program(1, "reload");

        // Program with the halt word at index 7
        for (int i = 0; i < 7; i++) load_words[i] = rnd_word();
        load_words[7] = HALT;
        load_program(8, "prog8");

        // Single step, then a full dump under random backpressure
        $display("[TB] single step");
        base = step_pulses;
        tx_q.delete();
        applyStimulus(8'h53);
        wait_idle("step", 5000);
        checkOutput("step_pulses", 64'(step_pulses - base), 64'd1);
        checkOutput("step_halted", {63'd0, halted}, 64'd0);
        check_dump(1, "step_dump");

        // Continuous run stops on the fetched halt word after 7 steps
        $display("[TB] run to halt word");
        do_reset();
        base = step_pulses;
        applyStimulus(8'h43);
        wait_idle("run", 5000);
        checkOutput("run_pulses", 64'(step_pulses - base), 64'd7);
        checkOutput("run_halted", {63'd0, halted}, 64'd1);
        check_dump(7, "run_dump");

        // Halted: step and run are ignored, load clears the flag
        base = step_pulses;
        applyStimulus(8'h53);
        applyStimulus(8'h43);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("hlt_busy", {63'd0, busy}, 64'd0);
        checkOutput("hlt_steps", 64'(step_pulses - base), 64'd0);
        checkOutput("hlt_tx", 64'(tx_q.size()), 64'd0);
        checkOutput("hlt_still", {63'd0, halted}, 64'd1);
        wr_q.delete();
        applyStimulus(8'h4C);
        applyStimulus(8'h00);
        wait_idle("lzero", 50);
        checkOutput("lzero_halted", {63'd0, halted}, 64'd0);
        checkOutput("lzero_writes", 64'(wr_q.size()), 64'd0);

        // Directed five-cycle stall in the middle of a dump
        $display("[TB] backpressure");
        tx_q.delete();
        base        = step_pulses;
        sbase       = stall_checks;
        ebase       = stall_errors;
        ready_force = 1'b1;
        ready_val   = 1'b1;
        applyStimulus(8'h53);
        n = 0;
        while (tx_q.size() < 41 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("bp_reached", {63'd0, tx_q.size() >= 41}, 64'd1);
        ready_val = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        ready_val = 1'b1;
        wait_idle("bp", 5000);
        ready_force = 1'b0;
        checkOutput("bp_stalled", {63'd0, (stall_checks - sbase) >= 1}, 64'd1);
        checkOutput("bp_stable", 64'(stall_errors - ebase), 64'd0);
        checkOutput("bp_pulses", 64'(step_pulses - base), 64'd1);
        check_dump(8, "bp_dump");

        // Cycle limit with no halt word in reach
        $display("[TB] run to cycle limit");
        for (int i = 0; i < 21; i++) load_words[i] = rnd_word();
        load_program(21, "prog21");
        do_reset();
        base = step_pulses;
        applyStimulus(8'h43);
        wait_idle("max", 5000);
        checkOutput("max_pulses", 64'(step_pulses - base), 64'(MAX_RUN));
        checkOutput("max_halted", {63'd0, halted}, 64'd1);
        check_dump(MAX_RUN, "max_dump");

        // Halt word fetched exactly when the limit is reached: one stop, one dump
        $display("[TB] halt word at the cycle limit");
        load_words[20] = HALT;
        load_program(21, "prog21h");
        do_reset();
        base = step_pulses;
        applyStimulus(8'h43);
        wait_idle("both", 5000);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("both_pulses", 64'(step_pulses - base), 64'(MAX_RUN));
        checkOutput("both_halted", {63'd0, halted}, 64'd1);
        check_dump(MAX_RUN, "both_dump");

        checkOutput("no_step_overlap", 64'(overlap_errors), 64'd0);
        checkOutput("all_stalls_stable", 64'(stall_errors), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_debug_controller.md
PIPELINE_DEBUG_CONTROLLER -- requirements
Module: pipeline_debug_controller

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- NB, 32, datapath word width.
- NB_REGS, 5, register-number width.
- MEM_WORDS, 16, data-memory words dumped.
- MAX_RUN, 1024, continuous-run cycle limit.
- HALT_WORD, 32'hFFFFFFFF, halt instruction.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- i_clk, in, 1, single clock.
- i_reset, in, 1, synchronous active-high reset.
- i_rx_data, in, 8, command/payload byte.
- i_rx_valid, in, 1, one-cycle byte strobe.
- o_tx_data, out, 8, dump byte.
- o_tx_valid, out, 1, dump byte valid.
- i_tx_ready, in, 1, sink accepts byte.
- o_step, out, 1, pipeline advance enable.
- o_instruction_write_enable, out, 1, instruction-memory write.
- o_instruction_address, out, NB, byte address.
- o_instruction_data, out, NB, instruction word.
- o_debug_register_number, out, NB_REGS, register-file debug select.
- o_debug_address, out, NB, data-memory debug word address.
- i_mips_pc, in, NB, IF-stage fetched word.
- i_mips_alu_result, in, NB, EX ALU result.
- i_mips_register_data, in, NB, selected register.
- i_mips_data_memory, in, NB, selected memory word.
- o_busy, out, 1, high outside IDLE.
- o_halted, out, 1, HALT_WORD fetched or MAX_RUN reached.

Function
REQ-003 FSM states SHALL be IDLE, LOAD_COUNT, LOAD_BYTE, LOAD_WRITE, STEP, RUN, DUMP_SEL, DUMP_WAIT, DUMP_SEND.
REQ-004 In IDLE, a valid 0x4C ('L') SHALL go to LOAD_COUNT, 0x53 ('S') to STEP, 0x43 ('C') to RUN; other bytes SHALL be ignored.
REQ-005 LOAD_COUNT SHALL latch the next byte as N words.
- N=0 SHALL return to IDLE with no write.
REQ-006 LOAD_BYTE SHALL assemble four bytes MSB-first, then enter LOAD_WRITE.
REQ-007 LOAD_WRITE SHALL assert o_instruction_write_enable for exactly one cycle, with address = 4*index and the assembled data.
- Then return to LOAD_BYTE, or to IDLE after word N.
REQ-008 Rx bytes arriving outside IDLE/LOAD_COUNT/LOAD_BYTE SHALL be dropped.
REQ-009 STEP SHALL assert o_step for exactly one cycle, then enter DUMP_SEL.
REQ-010 RUN SHALL assert o_step every cycle.
- On i_mips_pc==HALT_WORD or cycle count==MAX_RUN: deassert o_step, set o_halted, enter DUMP_SEL.
- Both conditions in the same cycle SHALL count as a single halt.
REQ-011 While o_halted=1, 'S' and 'C' SHALL be ignored; 'L' SHALL clear o_halted.
REQ-012 Dump SHALL send 2+32+MEM_WORDS words, 4 bytes each, MSB first, in this order:
- i_mips_pc.
- i_mips_alu_result.
- R0..R31 via o_debug_register_number.
- M0..M(MEM_WORDS-1) via o_debug_address = word index.
REQ-013 DUMP_SEL SHALL drive the select, DUMP_WAIT SHALL allow one cycle of read latency, and DUMP_SEND SHALL capture the word and emit its bytes.
REQ-014 Each byte SHALL hold o_tx_data stable with o_tx_valid=1 until the i_tx_ready cycle, then advance.
- After the final byte: o_tx_valid=0, state IDLE.
REQ-015 o_step SHALL be 0 during load and dump, so the pipeline is frozen while it is observed.

Reset
REQ-016 On i_reset: state IDLE; all outputs and counters 0; o_halted=0; assembly registers cleared.
REQ-017 Reset mid-load or mid-dump SHALL abort without a further write or tx byte.

Structure
REQ-018 Command codes, HALT_WORD, the state encoding, and dump word count SHALL live in a shared debug_pkg constants file.
REQ-019 The serializer (word -> 4 bytes with ready handshake) SHALL be a sub-module, word_serializer.

Verification
REQ-020 Load: 'L', 0x02, 8 bytes 0x20010005 0xFFFFFFFF -> two write pulses: address 0 data 0x20010005; address 4 data 0xFFFFFFFF.
REQ-021 Step: 'S' -> one o_step pulse, then exactly 200 tx bytes; byte 0 = i_mips_pc[31:24].
REQ-022 Run-halt: 'C' with HALT_WORD fetched on cycle 7 -> o_step high 7 cycles, o_halted=1, then dump.
REQ-023 Backpressure: i_tx_ready low 5 cycles mid-dump -> o_tx_data stable, no byte lost or duplicated.
REQ-024 Reset during LOAD_BYTE after 2 bytes -> no write, IDLE; fresh 'L' loads to address 0.
